// File: rtl/program_loader.sv
// program_loader: assembles a big-endian byte stream into 32-bit instruction
// words and issues single-cycle word writes into program memory.
// Optional build macro: PROGRAM_LOADER_CHECKSUM_EN adds a trailing checksum
// byte (sum of all data bytes mod 256) that sets Error on mismatch.
module program_loader #(
  parameter int unsigned             DATA_WIDTH   = 32,
  parameter int unsigned             MEMORY_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0]   BASE_ADDRESS = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start,
  input  logic [DATA_WIDTH-1:0] WordCount,
  input  logic [7:0]            ByteData,
  input  logic                  ByteValid,
  output logic                  ByteReady,
  output logic                  MemWrite,
  output logic [DATA_WIDTH-1:0] WriteAddress,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE
  } state_t;

  localparam logic [DATA_WIDTH-1:0] DEPTH_W    = DATA_WIDTH'(MEMORY_DEPTH);
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

  state_t                state_q;
  logic [DATA_WIDTH-1:0] wc_q;
  logic [DATA_WIDTH-1:0] idx_q;
  logic [1:0]            bcnt_q;
  logic [23:0]           asm_q;
  logic                  ready_q;
  logic                  memwr_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]            sum_q;
`endif

  logic [DATA_WIDTH-1:0] idx_d;
  logic [DATA_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] word_d;
  logic                  take;

  // Next word index, aligned target address and the word completed by the current byte.
  always_comb begin
    idx_d  = idx_q + DATA_WIDTH'(1);
    addr_d = (BASE_ADDRESS + (idx_q << 2)) & ALIGN_MASK;
    word_d = DATA_WIDTH'({asm_q, ByteData});
    take   = ByteValid && ready_q;
  end

  // Load sequencer; all outputs are registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      wc_q    <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      asm_q   <= '0;
      ready_q <= 1'b0;
      memwr_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      memwr_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          // ByteReady is low here, so a simultaneous byte is never consumed.
          if (Start) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            wc_q   <= WordCount;
            idx_q  <= '0;
            bcnt_q <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_q  <= '0;
`endif
            if (WordCount == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else if (WordCount > DEPTH_W) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= S_COLLECT;
              busy_q  <= 1'b1;
              ready_q <= 1'b1;
            end
          end
        end
        S_COLLECT: begin
          if (take) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_q <= sum_q + ByteData;
`endif
            if (bcnt_q == 2'd3) begin
              bcnt_q  <= '0;
              state_q <= S_WRITE;
              ready_q <= 1'b0;
              memwr_q <= 1'b1;
              addr_q  <= addr_d;
              data_q  <= word_d;
            end else begin
              bcnt_q <= bcnt_q + 2'd1;
              asm_q  <= {asm_q[15:0], ByteData};
            end
          end
        end
        S_WRITE: begin
          idx_q <= idx_d;
          if (idx_d == wc_q) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            state_q <= S_CHECK;
            ready_q <= 1'b1;
`else
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
`endif
          end else begin
            state_q <= S_COLLECT;
            ready_q <= 1'b1;
          end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (take) begin
            err_q   <= (ByteData != sum_q);
            state_q <= S_DONE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
`endif
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ByteReady    = ready_q;
  assign MemWrite     = memwr_q;
  assign WriteAddress = addr_q;
  assign WriteData    = data_q;
  assign Busy         = busy_q;
  assign Done         = done_q;
  assign Error        = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader (32-bit words, depth 32, base 0).
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [31:0] WordCount;
  logic [7:0]  ByteData;
  logic        ByteValid;
  logic        ByteReady;
  logic        MemWrite;
  logic [31:0] WriteAddress;
  logic [31:0] WriteData;
  logic        Busy;
  logic        Done;
  logic        Error;

  int   tests  = 0;
  int   failed = 0;
  int   wr_cnt = 0;
  int   wr_base;
  logic [7:0] csum;

  program_loader #(
    .DATA_WIDTH  (32),
    .MEMORY_DEPTH(32),
    .BASE_ADDRESS(32'h0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .Start       (Start),
    .WordCount   (WordCount),
    .ByteData    (ByteData),
    .ByteValid   (ByteValid),
    .ByteReady   (ByteReady),
    .MemWrite    (MemWrite),
    .WriteAddress(WriteAddress),
    .WriteData   (WriteData),
    .Busy        (Busy),
    .Done        (Done),
    .Error       (Error)
  );

  always #5 clk = ~clk;

  // Count every cycle in which a write strobe is seen.
  always @(negedge clk) if (MemWrite === 1'b1) wr_cnt <= wr_cnt + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] wc);
    Start     = 1'b1;
    WordCount = wc;
    csum      = 8'h00;
    tick();
    Start     = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int g = 0; g < gap; g++) begin
      ByteValid = 1'b0;
      tick();
    end
    ByteValid = 1'b1;
    ByteData  = b;
    tick();
    ByteValid = 1'b0;
    csum      = csum + b;
  endtask

  // Called right after the 4th byte edge: WRITE cycle, then the following cycle.
  task automatic check_write(input logic [31:0] w, input logic [31:0] a);
    check("wr_strobe", {31'b0, MemWrite}, 32'd1);
    check("wr_addr", WriteAddress, a);
    check("wr_data", WriteData, w);
    check("wr_ready", {31'b0, ByteReady}, 32'd0);
    check("wr_busy", {31'b0, Busy}, 32'd1);
    tick();
    check("wr_single", {31'b0, MemWrite}, 32'd0);
    check("wr_hold", WriteData, w);
  endtask

  task automatic load_word(input logic [31:0] w, input int gap, input logic [31:0] a);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] sh;
      sh = w >> (24 - 8 * k);
      send_byte(sh[7:0], gap);
    end
    check_write(w, a);
  endtask

  // End of a non-rejected load with one or more words.
  task automatic finish_load();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    check("chk_busy", {31'b0, Busy}, 32'd1);
    check("chk_ready", {31'b0, ByteReady}, 32'd1);
    ByteValid = 1'b1;
    ByteData  = csum;
    tick();
    ByteValid = 1'b0;
`endif
    check("end_done", {31'b0, Done}, 32'd1);
    check("end_err", {31'b0, Error}, 32'd0);
    check("end_busy", {31'b0, Busy}, 32'd0);
    check("end_ready", {31'b0, ByteReady}, 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    Start     = 1'b0;
    WordCount = '0;
    ByteData  = '0;
    ByteValid = 1'b0;
    csum      = '0;
    #2 reset = 1'b0;
    #1;
    check("rst_busy", {31'b0, Busy}, 32'd0);
    check("rst_done", {31'b0, Done}, 32'd0);
    check("rst_err", {31'b0, Error}, 32'd0);
    check("rst_ready", {31'b0, ByteReady}, 32'd0);
    check("rst_memwr", {31'b0, MemWrite}, 32'd0);
    check("rst_addr", WriteAddress, 32'h0);
    check("rst_data", WriteData, 32'h0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Basic back-to-back load of two words
    do_start(32'd2);
    check("t1_busy", {31'b0, Busy}, 32'd1);
    check("t1_ready", {31'b0, ByteReady}, 32'd1);
    check("t1_done", {31'b0, Done}, 32'd0);
    load_word(32'h20080005, 0, 32'h0);
    load_word(32'h01095020, 0, 32'h4);
    finish_load();
    check("t1_wrcnt", wr_cnt, 32'd2);

    // Gapped stream; a byte offered together with Start in DONE is not consumed
    wr_base   = wr_cnt;
    ByteValid = 1'b1;
    ByteData  = 8'hEE;
    do_start(32'd2);
    ByteValid = 1'b0;
    check("t2_done_clr", {31'b0, Done}, 32'd0);
    load_word(32'h20080005, 3, 32'h0);
    load_word(32'h01095020, 3, 32'h4);
    finish_load();
    check("t2_wrcnt", wr_cnt - wr_base, 32'd2);

    // WordCount = 0: done next cycle, no writes
    wr_base = wr_cnt;
    do_start(32'd0);
    check("t3a_done", {31'b0, Done}, 32'd1);
    check("t3a_err", {31'b0, Error}, 32'd0);
    check("t3a_busy", {31'b0, Busy}, 32'd0);
    tick();
    tick();
    check("t3a_wrcnt", wr_cnt - wr_base, 32'd0);

    // WordCount above depth: rejected
    do_start(32'd33);
    check("t3b_done", {31'b0, Done}, 32'd1);
    check("t3b_err", {31'b0, Error}, 32'd1);
    check("t3b_busy", {31'b0, Busy}, 32'd0);
    tick();
    tick();
    check("t3b_wrcnt", wr_cnt - wr_base, 32'd0);

    // Full depth: 32 words, last at 0x7C
    do_start(32'd32);
    check("t3c_err_clr", {31'b0, Error}, 32'd0);
    check("t3c_busy", {31'b0, Busy}, 32'd1);
    for (int i = 0; i < 32; i++) begin
      logic [7:0] bi;
      bi = 8'(i);
      load_word({bi, 8'hA5, ~bi, 8'h3C}, 0, 32'(4 * i));
    end
    check("t3c_last_addr", WriteAddress, 32'h7C);
    check("t3c_last_data", WriteData, 32'h1FA5E03C);
    finish_load();
    check("t3c_wrcnt", wr_cnt - wr_base, 32'd32);

    // Reset in the middle of a word aborts the load
    wr_base = wr_cnt;
    do_start(32'd1);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    #2 reset = 1'b0;
    #1;
    check("t4_rst_busy", {31'b0, Busy}, 32'd0);
    check("t4_rst_ready", {31'b0, ByteReady}, 32'd0);
    check("t4_rst_done", {31'b0, Done}, 32'd0);
    check("t4_rst_addr", WriteAddress, 32'h0);
    check("t4_rst_data", WriteData, 32'h0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("t4_rst_wrcnt", wr_cnt - wr_base, 32'd0);
    do_start(32'd1);
    load_word(32'hAABBCCDD, 0, 32'h0);
    finish_load();

    // Start pulse mid-load is ignored
    do_start(32'd2);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    Start     = 1'b1;
    WordCount = 32'd0;
    tick();
    Start     = 1'b0;
    check("t4_ign_busy", {31'b0, Busy}, 32'd1);
    check("t4_ign_done", {31'b0, Done}, 32'd0);
    check("t4_ign_ready", {31'b0, ByteReady}, 32'd1);
    send_byte(8'h33, 1);
    send_byte(8'h44, 0);
    check_write(32'h11223344, 32'h0);
    load_word(32'h55667788, 0, 32'h4);
    finish_load();

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Checksum match: 01+02+03+04 = 0A
    do_start(32'd1);
    load_word(32'h01020304, 0, 32'h0);
    check("t5_ready", {31'b0, ByteReady}, 32'd1);
    ByteValid = 1'b1;
    ByteData  = 8'h0A;
    tick();
    ByteValid = 1'b0;
    check("t5_ok_done", {31'b0, Done}, 32'd1);
    check("t5_ok_err", {31'b0, Error}, 32'd0);
    // Checksum mismatch
    do_start(32'd1);
    load_word(32'h01020304, 0, 32'h0);
    ByteValid = 1'b1;
    ByteData  = 8'h0B;
    tick();
    ByteValid = 1'b0;
    check("t5_bad_done", {31'b0, Done}, 32'd1);
    check("t5_bad_err", {31'b0, Error}, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
